// File: rtl/wave_view_pkg.sv
// wave_view_pkg: shared types and constants for the waveform view controller.
//   - state_t     : frame sequencer states
//   - view_cmd_t  : one resolved keypad command, consumed once per frame
//   - *_DEFAULT   : default geometry (columns, sample width, zoom range, pan)
//   - max_base    : largest legal window start for a given zoom
//   - clamp_base  : pins a candidate window start into [0, hi]
package wave_view_pkg;

  localparam int COLS_DEFAULT     = 640;
  localparam int SAMPLE_W_DEFAULT = 22;
  localparam int ZOOM_MAX_DEFAULT = 12;
  localparam int PAN_COLS_DEFAULT = 64;

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_APPLY,
    ST_ADDR,
    ST_NEXT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    ZOOM_HOLD,
    ZOOM_IN,
    ZOOM_OUT
  } zoom_cmd_t;

  typedef enum logic [1:0] {
    PAN_HOLD,
    PAN_LEFT,
    PAN_RIGHT
  } pan_cmd_t;

  typedef struct packed {
    logic      home;
    zoom_cmd_t zoom;
    pan_cmd_t  pan;
  } view_cmd_t;

  // Window of 'cols' columns at stride 2^zoom must end inside the sample
  // space, so the start may be at most 2^sample_w - (cols << zoom).
  // 32-bit signed arithmetic covers sample_w up to 30.
  function automatic logic signed [31:0] max_base(input int         sample_w,
                                                  input int         cols,
                                                  input logic [3:0] zoom);
    logic signed [31:0] span;
    span = 32'(cols) << zoom;
    return (32'sd1 <<< sample_w) - span;
  endfunction

  function automatic logic signed [31:0] clamp_base(input logic signed [31:0] value,
                                                    input logic signed [31:0] hi);
    if (value < 0)  return 32'sd0;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/wave_view_keys.sv
// wave_view_keys: sticky pending bits for the five keypad commands and the
// home > zoom > pan priority / cancel resolution.
// Ports:
//   clk, reset            : memory clock, synchronous active-high reset
//   key_left/right/zin/zout/home : single-cycle command pulses
//   apply                 : high for the one cycle the view is updated;
//                           clears the pending bits (new pulses still land)
//   cmd                   : resolved command from the current pending bits
module wave_view_keys
  import wave_view_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      key_left,
  input  logic      key_right,
  input  logic      key_zin,
  input  logic      key_zout,
  input  logic      key_home,
  input  logic      apply,
  output view_cmd_t cmd
);

  // {home, zout, zin, right, left}
  logic [4:0] pend;

  // A pulse in the apply cycle is OR-ed in after the clear, so it is
  // carried into the next frame instead of being dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else begin
      pend <= (apply ? 5'b0 : pend) | {key_home, key_zout, key_zin, key_right, key_left};
    end
  end

  always_comb begin
    cmd.home = pend[4];
    cmd.zoom = ZOOM_HOLD;
    cmd.pan  = PAN_HOLD;
    if (!pend[4]) begin
      // Opposite keys in the same frame cancel.
      if (pend[2] && !pend[3]) cmd.zoom = ZOOM_IN;
      if (pend[3] && !pend[2]) cmd.zoom = ZOOM_OUT;
      if (pend[0] && !pend[1]) cmd.pan  = PAN_LEFT;
      if (pend[1] && !pend[0]) cmd.pan  = PAN_RIGHT;
    end
  end

endmodule

// File: rtl/wave_view_ctrl.sv
// wave_view_ctrl: pan/zoom view controller and PSRAM read-burst sequencer.
// On each synchronised vsync rising edge the queued keypad command is applied
// to the view (base sample, zoom shift), then one read-burst address per
// screen column is issued at a column stride of 2^zoom samples.
// Build option: define WAVE_VIEW_CLAMP_EN to clamp the window start to
// [0, 2^SAMPLE_W - (COLS << zoom)]; otherwise base arithmetic wraps.
// Ports:
//   clk, reset     : memory clock, synchronous active-high reset
//   psram_ready    : PSRAM initialised; low forces STARTUP
//   vsync          : pixel-domain vsync (asynchronous, synchronised here)
//   key_*          : keypad command pulses
//   araddr/arvalid/arready : PSRAM read-address handshake, araddr = {sample,3'b0}
//   col_idx        : column of the burst being issued
//   view_base/view_zoom : current window start and zoom shift
//   busy           : high in APPLY, ADDR, NEXT
//   frame_done     : one-cycle pulse after the last burst is accepted
//   overrun        : one-cycle pulse when a vsync edge arrives outside IDLE
module wave_view_ctrl
  import wave_view_pkg::*;
#(
  parameter int COLS     = COLS_DEFAULT,
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
  parameter int ZOOM_MAX = ZOOM_MAX_DEFAULT,
  parameter int PAN_COLS = PAN_COLS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                psram_ready,
  input  logic                vsync,
  input  logic                key_left,
  input  logic                key_right,
  input  logic                key_zin,
  input  logic                key_zout,
  input  logic                key_home,
  output logic [SAMPLE_W+2:0] araddr,
  output logic                arvalid,
  input  logic                arready,
  output logic [9:0]          col_idx,
  output logic [SAMPLE_W-1:0] view_base,
  output logic [3:0]          view_zoom,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun
);

  state_t              state;
  logic                vs_meta, vs_sync, vs_prev, vs_rise;
  view_cmd_t           cmd;
  logic                apply;
  logic [3:0]          zoom_nxt;
  logic [SAMPLE_W-1:0] base_nxt;
  logic [SAMPLE_W-1:0] cur_sample;
  logic [SAMPLE_W-1:0] stride;
  logic [SAMPLE_W-1:0] sample_nxt;

  // ---- stage p0: vsync synchroniser and registered edge detect ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
      vs_rise <= 1'b0;
    end else begin
      vs_meta <= vsync;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
      vs_rise <= vs_sync & ~vs_prev;
    end
  end

  // An APPLY cut short by psram_ready leaves the pending keys queued.
  assign apply = (state == ST_APPLY) && psram_ready;

  wave_view_keys u_keys (
    .clk       (clk),
    .reset     (reset),
    .key_left  (key_left),
    .key_right (key_right),
    .key_zin   (key_zin),
    .key_zout  (key_zout),
    .key_home  (key_home),
    .apply     (apply),
    .cmd       (cmd)
  );

  // ---- stage p1: next view from the resolved command ----
`ifdef WAVE_VIEW_CLAMP_EN
  logic signed [31:0] pan_step;
  logic signed [31:0] base_wide;
`else
  logic [SAMPLE_W-1:0] pan_step;
`endif

  always_comb begin
    zoom_nxt = view_zoom;
    case (cmd.zoom)
      ZOOM_IN:  if (view_zoom != 4'd0)           zoom_nxt = view_zoom - 4'd1;
      ZOOM_OUT: if (view_zoom < 4'(ZOOM_MAX))    zoom_nxt = view_zoom + 4'd1;
      default:  ;
    endcase
    // Pan distance is measured in columns at the new zoom; the left edge
    // stays where it was when only the zoom changes.
`ifdef WAVE_VIEW_CLAMP_EN
    pan_step  = 32'(PAN_COLS) << zoom_nxt;
    base_wide = 32'(view_base);
    case (cmd.pan)
      PAN_LEFT:  base_wide = base_wide - pan_step;
      PAN_RIGHT: base_wide = base_wide + pan_step;
      default:   ;
    endcase
    base_nxt = SAMPLE_W'(clamp_base(base_wide, max_base(SAMPLE_W, COLS, zoom_nxt)));
`else
    pan_step = SAMPLE_W'(PAN_COLS) << zoom_nxt;
    base_nxt = view_base;
    case (cmd.pan)
      PAN_LEFT:  base_nxt = view_base - pan_step;
      PAN_RIGHT: base_nxt = view_base + pan_step;
      default:   ;
    endcase
`endif
    if (cmd.home) begin
      zoom_nxt = 4'd0;
      base_nxt = '0;
    end
  end

  // Column stride is a one-hot decode of the zoom; the address itself is
  // stepped by addition only.
  assign stride     = SAMPLE_W'(1) << view_zoom;
  assign sample_nxt = cur_sample + stride;

  always_ff @(posedge clk) begin
    if (state == ST_APPLY)     cur_sample <= base_nxt;
    else if (state == ST_NEXT) cur_sample <= sample_nxt;
  end

  // ---- stage p2: frame sequencer with registered outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_STARTUP;
      arvalid    <= 1'b0;
      araddr     <= '0;
      col_idx    <= '0;
      view_base  <= '0;
      view_zoom  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= vs_rise && (state != ST_IDLE);
      if (!psram_ready) begin
        state   <= ST_STARTUP;
        arvalid <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_STARTUP: state <= ST_IDLE;
          ST_IDLE: begin
            if (vs_rise) begin
              state <= ST_APPLY;
              busy  <= 1'b1;
            end
          end
          ST_APPLY: begin
            view_base <= base_nxt;
            view_zoom <= zoom_nxt;
            col_idx   <= '0;
            araddr    <= {base_nxt, 3'b000};
            arvalid   <= 1'b1;
            state     <= ST_ADDR;
          end
          ST_ADDR: begin
            if (arready) begin
              arvalid <= 1'b0;
              state   <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            if (col_idx == 10'(COLS - 1)) begin
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= ST_DONE;
            end else begin
              col_idx <= col_idx + 10'd1;
              araddr  <= {sample_nxt, 3'b000};
              arvalid <= 1'b1;
              state   <= ST_ADDR;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_STARTUP;
        endcase
      end
    end
  end

endmodule
